// File: rtl/fp32_add_pipe.sv
// rtl/fp32_add_pipe.sv - two-stage IEEE-754 binary32 adder, round-to-nearest-even
// Defining FPA_FLAGS_EN adds a registered flags[4:0] output {invalid, div0, overflow, underflow, inexact}.
module fp32_add_pipe (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] number_A,
   input  logic [31:0] number_B,
`ifdef FPA_FLAGS_EN
   output logic [4:0]  flags,
`endif
   output logic [31:0] number_out
);

   logic        a_exp_max, b_exp_max, a_nan, b_nan, a_inf, b_inf;
   logic        swap;
   logic [31:0] op_big, op_sml;
   logic [7:0]  e_big, e_sml, diff;
   logic [4:0]  align_sh;
   logic [49:0] sml_ext;

   logic        special_d, sign_d, sub_d, zero_sign_d, sticky_d;
   logic [31:0] special_val_d;
   logic [7:0]  exp_d;
   logic [23:0] m_big_d;
   logic [25:0] m_sml_d;

   logic        s1_special_q, s1_sign_q, s1_sub_q, s1_zero_sign_q, s1_sticky_q;
   logic [31:0] s1_special_val_q;
   logic [7:0]  s1_exp_q;
   logic [23:0] s1_m_big_q;
   logic [25:0] s1_m_sml_q;

   assign a_exp_max = &number_A[30:23];
   assign b_exp_max = &number_B[30:23];
   assign a_nan     = a_exp_max & (|number_A[22:0]);
   assign b_nan     = b_exp_max & (|number_B[22:0]);
   assign a_inf     = a_exp_max & ~(|number_A[22:0]);
   assign b_inf     = b_exp_max & ~(|number_B[22:0]);

   // Ordering on the raw magnitude bits is the same as ordering on value for finite operands.
   assign swap   = number_B[30:0] > number_A[30:0];
   assign op_big = swap ? number_B : number_A;
   assign op_sml = swap ? number_A : number_B;

   assign e_big    = (op_big[30:23] == 8'd0) ? 8'd1 : op_big[30:23];
   assign e_sml    = (op_sml[30:23] == 8'd0) ? 8'd1 : op_sml[30:23];
   assign diff     = e_big - e_sml;
   assign align_sh = (diff > 8'd26) ? 5'd26 : diff[4:0];
   // Window [49:24] keeps significand, guard and round; everything below folds into sticky.
   assign sml_ext  = {(|op_sml[30:23]), op_sml[22:0], 26'd0} >> align_sh;

   assign sign_d      = op_big[31];
   assign sub_d       = number_A[31] ^ number_B[31];
   assign zero_sign_d = number_A[31] & number_B[31];
   assign exp_d       = e_big;
   assign m_big_d     = {(|op_big[30:23]), op_big[22:0]};
   assign m_sml_d     = sml_ext[49:24];
   assign sticky_d    = |sml_ext[23:0];

   always_comb begin
      special_d     = 1'b1;
      special_val_d = 32'h0000_0000;
      if (a_nan)
         special_val_d = number_A | 32'h0040_0000;
      else if (b_nan)
         special_val_d = number_B | 32'h0040_0000;
      else if (a_inf && b_inf && (number_A[31] != number_B[31]))
         special_val_d = 32'hFFC0_0000;
      else if (a_inf)
         special_val_d = number_A;
      else if (b_inf)
         special_val_d = number_B;
      else
         special_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_special_q     <= 1'b0;
         s1_special_val_q <= 32'h0000_0000;
         s1_sign_q        <= 1'b0;
         s1_sub_q         <= 1'b0;
         s1_zero_sign_q   <= 1'b0;
         s1_exp_q         <= 8'd0;
         s1_m_big_q       <= 24'd0;
         s1_m_sml_q       <= 26'd0;
         s1_sticky_q      <= 1'b0;
      end else begin
         s1_special_q     <= special_d;
         s1_special_val_q <= special_val_d;
         s1_sign_q        <= sign_d;
         s1_sub_q         <= sub_d;
         s1_zero_sign_q   <= zero_sign_d;
         s1_exp_q         <= exp_d;
         s1_m_big_q       <= m_big_d;
         s1_m_sml_q       <= m_sml_d;
         s1_sticky_q      <= sticky_d;
      end
   end

   logic [27:0] sum;
   logic [4:0]  lz, norm_sh;
   logic [8:0]  exp9, lim, exp_n, e_field;
   logic [26:0] norm;
   logic        g_bit, r_bit, s_bit, rnd_up, ovf;
   logic [31:0] res_mag, out_d, s2_out_q;

   // Sticky sits in the LSB so a subtraction borrows through it, keeping G/R exact.
   always_comb begin
      if (s1_sub_q)
         sum = {1'b0, s1_m_big_q, 3'b000} - {1'b0, s1_m_sml_q, s1_sticky_q};
      else
         sum = {1'b0, s1_m_big_q, 3'b000} + {1'b0, s1_m_sml_q, s1_sticky_q};
   end

   always_comb begin
      lz = 5'd27;
      for (int i = 0; i < 27; i++)
         if (sum[i]) lz = 5'(26 - i);
   end

   assign exp9 = {1'b0, s1_exp_q};
   assign lim  = exp9 - 9'd1;

   always_comb begin
      norm_sh = 5'd0;
      if (sum[27]) begin
         norm  = {sum[27:2], sum[1] | sum[0]};
         exp_n = exp9 + 9'd1;
      end else begin
         // Cap the shift so the exponent stops at 1; a short result then stays subnormal.
         norm_sh = ({4'd0, lz} > lim) ? lim[4:0] : lz;
         norm    = sum[26:0] << norm_sh;
         exp_n   = exp9 - {4'd0, norm_sh};
      end
   end

   assign e_field = norm[26] ? exp_n : 9'd0;
   assign g_bit   = norm[2];
   assign r_bit   = norm[1];
   assign s_bit   = norm[0];
   assign rnd_up  = g_bit & (r_bit | s_bit | norm[3]);
   // Mantissa carry ripples into the exponent field, which also promotes subnormals to normal.
   assign res_mag = {e_field, norm[25:3]} + {31'd0, rnd_up};
   assign ovf     = res_mag[31:23] >= 9'd255;

   always_comb begin
      if (s1_special_q)
         out_d = s1_special_val_q;
      else if (ovf)
         out_d = {s1_sign_q, 8'hFF, 23'd0};
      else if (sum == 28'd0)
         out_d = {s1_zero_sign_q, 31'd0};
      else
         out_d = {s1_sign_q, res_mag[30:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s2_out_q <= 32'h0000_0000;
      else        s2_out_q <= out_d;
   end

   assign number_out = s2_out_q;

`ifdef FPA_FLAGS_EN
   logic       invalid_d, s1_invalid_q, inexact_d;
   logic [4:0] flags_d, s2_flags_q;

   assign invalid_d = (a_inf & b_inf & (number_A[31] != number_B[31]))
                    | (a_nan & ~number_A[22]) | (b_nan & ~number_B[22]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s1_invalid_q <= 1'b0;
      else        s1_invalid_q <= invalid_d;
   end

   assign inexact_d = ~s1_special_q & (g_bit | r_bit | s_bit | ovf);
   assign flags_d   = {s1_invalid_q, 1'b0, ~s1_special_q & ovf,
                       ~s1_special_q & ~norm[26] & (g_bit | r_bit | s_bit), inexact_d};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s2_flags_q <= 5'd0;
      else        s2_flags_q <= flags_d;
   end

   assign flags = s2_flags_q;
`endif

endmodule

// File: tb/tb_fp32_add_pipe.sv
// tb/tb_fp32_add_pipe.sv - directed and randomized bench for fp32_add_pipe
// Reference model adds exactly in a wide integer scaled by 2^149, then rounds once.
module tb_fp32_add_pipe;

   logic        clk;
   logic        rst_n;
   logic [31:0] number_A, number_B, number_out;
`ifdef FPA_FLAGS_EN
   logic [4:0]  flags;
`endif

   int          checks;
   int          errors;
   logic [31:0] pend_exp;
   logic        pend_vld;
   string       pend_tag;

   fp32_add_pipe dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .number_A   (number_A),
      .number_B   (number_B),
`ifdef FPA_FLAGS_EN
      .flags      (flags),
`endif
      .number_out (number_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic logic [299:0] scaled(input logic [31:0] x);
      logic [299:0] sig;
      int           e;
      sig = {276'd0, (x[30:23] != 8'd0), x[22:0]};
      e   = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
      return sig << (e - 1);
   endfunction

   function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
      logic         a_nan, b_nan, a_inf, b_inf, rs;
      logic [299:0] ma, mb, mag, rem, half, mant;
      logic [31:0]  enc;
      int           p, sh;
      a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      if (a_nan) return a | 32'h0040_0000;
      if (b_nan) return b | 32'h0040_0000;
      if (a_inf && b_inf && (a[31] != b[31])) return 32'hFFC0_0000;
      if (a_inf) return a;
      if (b_inf) return b;
      ma = scaled(a);
      mb = scaled(b);
      if (a[31] == b[31]) begin
         mag = ma + mb; rs = a[31];
      end else if (ma >= mb) begin
         mag = ma - mb; rs = a[31];
      end else begin
         mag = mb - ma; rs = b[31];
      end
      if (mag == 300'd0) return {a[31] & b[31], 31'd0};
      p = 0;
      for (int i = 0; i < 300; i++)
         if (mag[i]) p = i;
      if (p <= 23) return {rs, mag[30:0]};
      sh   = p - 23;
      mant = mag >> sh;
      rem  = mag & ((300'd1 << sh) - 300'd1);
      half = 300'd1 << (sh - 1);
      enc  = (32'(sh) << 23) + {8'd0, mant[23:0]};
      if ((rem > half) || ((rem == half) && mant[0])) enc = enc + 32'd1;
      if (enc >= 32'h7F80_0000) return {rs, 31'h7F80_0000};
      return {rs, enc[30:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      logic        s;
      logic [22:0] f;
      s = 1'($urandom_range(0, 1));
      f = 23'($urandom());
      case ($urandom_range(0, 9))
         0:       return {s, 31'd0};
         1:       return {s, 8'h00, f};
         2:       return {s, 8'hFF, 23'd0};
         3:       return {s, 8'hFF, (f == 23'd0) ? 23'd1 : f};
         4:       return {s, 8'($urandom_range(250, 254)), f};
         5:       return {s, 8'($urandom_range(1, 3)), f};
         default: return {s, 8'($urandom_range(1, 254)), f};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, got, expv);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input string tag);
      number_A = a;
      number_B = b;
      @(posedge clk);
      #1;
      if (pend_vld) check(pend_tag, number_out, pend_exp);
      pend_exp = ref_add(a, b);
      pend_tag = tag;
      pend_vld = 1'b1;
   endtask

   logic [31:0] ra, rb;

   initial begin
      checks   = 0;
      errors   = 0;
      pend_vld = 1'b0;
      pend_exp = 32'd0;
      pend_tag = "";
      rst_n    = 1'b0;
      number_A = 32'h3F80_0000;
      number_B = 32'h4000_0000;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", number_out, 32'h0000_0000);
      rst_n = 1'b1;

      drive(32'h0000_0000, 32'h8000_0000, "pz_plus_nz");
      check("ref_pz_nz", ref_add(32'h0000_0000, 32'h8000_0000), 32'h0000_0000);
      drive(32'h8000_0000, 32'h8000_0000, "nz_plus_nz");
      drive(32'h0000_0000, 32'h0000_0001, "zero_plus_sub");
      drive(32'h7F80_0000, 32'h3F80_0000, "inf_plus_one");
      drive(32'h7F80_0000, 32'hFF80_0000, "inf_minus_inf");
      drive(32'h7F80_0001, 32'h7F80_0000, "snan_a");
      drive(32'h0000_0000, 32'hFF80_1234, "nan_b");
      drive(32'h007F_FFFF, 32'h0000_0001, "sub_to_normal");
      drive(32'h0080_0000, 32'h8000_0001, "normal_to_sub");
      drive(32'h3F80_0000, 32'h3380_0000, "tie_even_down");
      drive(32'h3F80_0001, 32'h3380_0000, "tie_even_up");
      drive(32'h7F7F_FFFF, 32'h7F7F_FFFF, "max_overflow");
      drive(32'h3F80_0000, 32'hBF80_0000, "x_minus_x");
      drive(32'h8000_0000, 32'h8000_0000, "flush_directed");
      check("exp_nz_nz", pend_exp, 32'h8000_0000);

      for (int i = 0; i < 3000; i++) begin
         ra = rand_op();
         case ($urandom_range(0, 3))
            0:       rb = {~ra[31], ra[30:0] + 31'($urandom_range(0, 3))};
            1:       rb = {1'($urandom_range(0, 1)), ra[30:23], 23'($urandom())};
            default: rb = rand_op();
         endcase
         drive(ra, rb, $sformatf("rand_%0d", i));
      end

      #2;
      rst_n = 1'b0;
      #1;
      check("reset_async", number_out, 32'h0000_0000);
      pend_vld = 1'b0;
      @(posedge clk);
      #1;
      check("reset_held", number_out, 32'h0000_0000);
      rst_n = 1'b1;
      drive(32'h4040_0000, 32'h3F80_0000, "post_reset_first");
      drive(32'h4120_0000, 32'hC000_0000, "post_reset_second");
      drive(32'h0000_0000, 32'h0000_0000, "post_reset_flush");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp32_add_pipe.md
Name: fp32_add_pipe

Overview:
- Pipelined IEEE-754 binary32 adder.
- Computes number_A + number_B with round-to-nearest-even. Full handling of zeros, subnormals, infinities and NaNs.
- Used as a free-running datapath element: new operands are accepted every clock and a result is produced every clock. There is no handshake.

Parameters:
- None. Format is fixed at binary32 (1 sign, 8 exponent, 23 fraction bits).

Ports:
- clk  input  1  rising-edge clock. One clock; reset is asynchronous and active-low.
- rst_n  input  1  asynchronous active-low reset.
- number_A  input  32  operand A, IEEE-754 binary32.
- number_B  input  32  operand B, IEEE-754 binary32.
- number_out  output  32  registered sum, IEEE-754 binary32.

Behaviour:
- Reset:
  - rst_n low immediately clears all pipeline registers, with no clock required.
  - number_out = 32'h0000_0000 while rst_n is low.
  - Reset asserted mid-operation discards all in-flight results.
- Latency:
  - Exactly 2 clocks. Operands present before rising edge N appear on number_out after rising edge N+1.
  - Stage 1 registers unpacked/aligned operands. Stage 2 registers the normalized, rounded result.
  - Throughput is one result per clock.
  - After reset release, the first two edges flush in results for whatever operands are present.
- Result must be bit-identical to IEEE-754 binary32 addition, RNE:
  - Unpacking: exp=0 with frac≠0 is subnormal (hidden bit 0, effective exponent 1). exp=0 with frac=0 is zero. exp=255 with frac=0 is infinity. exp=255 with frac≠0 is NaN.
  - Alignment: shift the smaller-magnitude significand right by the exponent difference. Keep guard, round and sticky bits. Any shift ≥ 26 collapses the operand to sticky only.
  - Effective subtraction when signs differ. The result sign is the sign of the larger-magnitude operand.
  - Normalization: use a leading-zero count and left shift. The left shift is limited so the exponent never drops below 1; the result becomes subnormal or exactly zero.
  - Rounding: RNE on guard/round/sticky. A mantissa carry-out increments the exponent. A subnormal rounding up to 2^-126 becomes the smallest normal.
  - Overflow: a result exponent ≥ 255 after rounding gives ±infinity (32'h7F80_0000 / 32'hFF80_0000).
- Zero rules:
  - +0 + +0 = +0.
  - -0 + -0 = -0.
  - +0 + -0 = +0.
  - x + (-x) = +0 for any finite x.
  - 0 + y = y exactly, including subnormal y and sign of y.
- Special rules, evaluated in this priority:
  - A is NaN: out = A with bit 22 forced to 1 (quieted).
  - Otherwise B is NaN: out = B with bit 22 forced to 1.
  - Both infinite with opposite signs: out = 32'hFFC0_0000 (default NaN).
  - Otherwise either operand infinite: out = that infinity.
- No exceptions or traps. No X on outputs for any 32-bit input pattern.

Optional Feature:
- Macro FPA_FLAGS_EN.
- When defined, add output port flags[4:0] = {invalid, div0(always 0), overflow, underflow, inexact}:
  - flags are registered alongside number_out with the same 2-clock latency.
  - flags reset to 0.
  - invalid = inf-inf or any signalling NaN input (bit22=0).
  - overflow = rounded result overflowed to infinity.
  - underflow = tiny and inexact.
  - inexact = any nonzero guard/round/sticky bit, or overflow.
- When not defined, the port does not exist and no flag logic is synthesized. number_out is identical in both builds.

Test Plan:
- Zeros: A=32'h0000_0000, B=32'h8000_0000 → 32'h0000_0000. A=32'h8000_0000, B=32'h8000_0000 → 32'h8000_0000. Zero+subnormal 32'h0000_0001 → 32'h0000_0001. Check each output exactly 2 clocks after the inputs are applied.
- Infinity/NaN:
  - 32'h7F80_0000+32'h3F80_0000 → 32'h7F80_0000.
  - 32'h7F80_0000+32'hFF80_0000 → 32'hFFC0_0000.
  - 32'h7F80_0001+32'h7F80_0000 → 32'h7FC0_0001.
  - 32'h0000_0000+32'hFF80_1234 → 32'hFFC0_1234.
- Subnormal/normal boundary: 32'h007F_FFFF+32'h0000_0001 → 32'h0080_0000. 32'h0080_0000+32'h8000_0001 → 32'h007F_FFFF.
- Rounding and overflow:
  - 1.0 (32'h3F80_0000)+2^-24 (32'h3380_0000) → 32'h3F80_0000 (tie to even).
  - 32'h3F80_0001+32'h3380_0000 → 32'h3F80_0002.
  - 32'h7F7F_FFFF+32'h7F7F_FFFF → 32'h7F80_0000.
  - 1.0+(-1.0) → 32'h0000_0000.
- Random regression: back-to-back random operands every clock, with exponent classes swept across zero, subnormal, normal, inf and NaN. Each result must match a shortreal-add reference model, delayed by 2 cycles.
- Reset: assert rst_n low between clock edges mid-stream → number_out becomes 0 immediately. After release, the first valid result appears on the second rising edge.
